// File: rtl/matrix_3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator and its consumers.
package matrix_3x3_gen_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Row counter stops here: from the third line onward the full window is inside the image.
  localparam logic [1:0] ROW_SAT = 2'd2;

  localparam int unsigned WIN_DIM = 3;

  // Window row indices: top is two lines back, bottom is the current line.
  localparam int unsigned WIN_TOP = 0;
  localparam int unsigned WIN_MID = 1;
  localparam int unsigned WIN_BOT = 2;

  // Window column indices: NEW is the most recent pixel.
  localparam int unsigned WIN_OLD  = 0;
  localparam int unsigned WIN_PREV = 1;
  localparam int unsigned WIN_NEW  = 2;

endpackage

// File: rtl/matrix_3x3_gen_line_buf.sv
// One-line pixel store: one write port, one registered read port.
// A read and a write at the same address in one cycle return the old contents.
module matrix_3x3_gen_line_buf #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/matrix_3x3_gen.sv
// Streaming 3x3 neighbourhood generator with two line buffers.
// Optional feature: define MATRIX_EDGE_MASK_EN to zero window taps outside the image.
module matrix_3x3_gen
  import matrix_3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_data,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

  logic              pix_en;
  logic [CW-1:0]     col;
  logic [1:0]        row;
  logic              vsync_prev;
  logic              href_prev;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic [DATA_W-1:0] r3;
  logic [CW-1:0]     col_s1;
  logic              v1;
  logic [1:0]        vsync_dly;
  logic [1:0]        href_dly;
  logic [1:0]        clken_dly;
  logic [DATA_W-1:0] win    [WIN_DIM][WIN_DIM];
  logic [DATA_W-1:0] win_nx [WIN_DIM][WIN_DIM];
`ifdef MATRIX_EDGE_MASK_EN
  logic [1:0]        row_s1;
`endif

  assign pix_en = per_frame_clken & per_frame_href;

  // Column and row position of the incoming pixel; vsync rise overrides href fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      vsync_prev <= per_frame_vsync;
      href_prev  <= per_frame_href;
      if (!per_frame_href) begin
        col <= '0;
      end else if (per_frame_clken) begin
        col <= (col == COL_MAX) ? '0 : col + 1'b1;
      end
      if (per_frame_vsync && !vsync_prev) begin
        row <= '0;
      end else if (!per_frame_href && href_prev && (row != ROW_SAT)) begin
        row <= row + 2'd1;
      end
    end
  end

  // Previous line; its registered read port is the stage-1 middle row.
  matrix_3x3_gen_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W)
  ) u_buf_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pix_en),
    .waddr (col),
    .wdata (per_img_data),
    .re    (pix_en),
    .raddr (col),
    .rdata (r2)
  );

  // Line before that; fed from A's read data one cycle later at the same column.
  matrix_3x3_gen_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W)
  ) u_buf_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (v1),
    .waddr (col_s1),
    .wdata (r2),
    .re    (pix_en),
    .raddr (col),
    .rdata (r1)
  );

  // Stage 1: capture the current pixel and its position alongside the buffer reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      r3     <= '0;
      col_s1 <= '0;
`ifdef MATRIX_EDGE_MASK_EN
      row_s1 <= '0;
`endif
    end else begin
      v1 <= pix_en;
      if (pix_en) begin
        r3     <= per_img_data;
        col_s1 <= col;
`ifdef MATRIX_EDGE_MASK_EN
        row_s1 <= row;
`endif
      end
    end
  end

  // Sync strobes follow the two-stage data pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_dly <= '0;
      href_dly  <= '0;
      clken_dly <= '0;
    end else begin
      vsync_dly <= {vsync_dly[0], per_frame_vsync};
      href_dly  <= {href_dly[0], per_frame_href};
      clken_dly <= {clken_dly[0], per_frame_clken};
    end
  end

  // Next window: shift every row left, load the new column, then optionally mask borders.
  always_comb begin
    for (int i = 0; i < WIN_DIM; i++) begin
      win_nx[i][WIN_OLD]  = win[i][WIN_PREV];
      win_nx[i][WIN_PREV] = win[i][WIN_NEW];
      win_nx[i][WIN_NEW]  = '0;
    end
    win_nx[WIN_TOP][WIN_NEW] = r1;
    win_nx[WIN_MID][WIN_NEW] = r2;
    win_nx[WIN_BOT][WIN_NEW] = r3;
`ifdef MATRIX_EDGE_MASK_EN
    for (int j = 0; j < WIN_DIM; j++) begin
      if (row_s1 == 2'd0) begin
        win_nx[WIN_TOP][j] = '0;
        win_nx[WIN_MID][j] = '0;
      end else if (row_s1 == 2'd1) begin
        win_nx[WIN_TOP][j] = '0;
      end
    end
    for (int i = 0; i < WIN_DIM; i++) begin
      if (col_s1 == '0) begin
        win_nx[i][WIN_OLD]  = '0;
        win_nx[i][WIN_PREV] = '0;
      end else if (col_s1 == CW'(1)) begin
        win_nx[i][WIN_OLD] = '0;
      end
    end
`endif
  end

  // Stage 2: window register advances only on a valid stage-1 pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win <= '{default: '0};
    end else if (v1) begin
      win <= win_nx;
    end
  end

  assign matrix_frame_vsync = vsync_dly[1];
  assign matrix_frame_href  = href_dly[1];
  assign matrix_frame_clken = clken_dly[1];

  assign matrix_p11 = win[WIN_TOP][WIN_OLD];
  assign matrix_p12 = win[WIN_TOP][WIN_PREV];
  assign matrix_p13 = win[WIN_TOP][WIN_NEW];
  assign matrix_p21 = win[WIN_MID][WIN_OLD];
  assign matrix_p22 = win[WIN_MID][WIN_PREV];
  assign matrix_p23 = win[WIN_MID][WIN_NEW];
  assign matrix_p31 = win[WIN_BOT][WIN_OLD];
  assign matrix_p32 = win[WIN_BOT][WIN_PREV];
  assign matrix_p33 = win[WIN_BOT][WIN_NEW];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Randomised bench for matrix_3x3_gen against a stream-history reference model.
module tb_matrix_3x3_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned H  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic [DW-1:0] per_img_data;
  logic          matrix_frame_vsync;
  logic          matrix_frame_href;
  logic          matrix_frame_clken;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;

  matrix_3x3_gen #(
    .IMG_WIDTH (W),
    .DATA_W    (DW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_data       (per_img_data),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_href  (matrix_frame_href),
    .matrix_frame_clken (matrix_frame_clken),
    .matrix_p11         (matrix_p11),
    .matrix_p12         (matrix_p12),
    .matrix_p13         (matrix_p13),
    .matrix_p21         (matrix_p21),
    .matrix_p22         (matrix_p22),
    .matrix_p23         (matrix_p23),
    .matrix_p31         (matrix_p31),
    .matrix_p32         (matrix_p32),
    .matrix_p33         (matrix_p33)
  );

  always #5 clk = ~clk;

  // Taps are -1 where the value depends on never-written line memory.
  typedef struct { int t[9]; } win_t;
  typedef struct { int v[3]; } col_t;

  int   vectors     = 0;
  int   miscompares = 0;
  win_t exp_q[$];
  col_t stream_q[$];
  int   last_v[W];
  int   prev_v[W];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // After reset the window registers hold zeros: seed the column history with two zero columns.
  task automatic model_reset();
    col_t z;
    z.v = '{0, 0, 0};
    stream_q.delete();
    stream_q.push_back(z);
    stream_q.push_back(z);
  endtask

  // Column 3 of a window is the pixel, then the last two values seen at that column.
  task automatic model_push(input int line, input int c, input int d);
    col_t nv;
    win_t w;
    int   n;
    int   rr;
    nv.v[2] = d;
    nv.v[1] = last_v[c];
    nv.v[0] = prev_v[c];
    prev_v[c] = last_v[c];
    last_v[c] = d;
    stream_q.push_back(nv);
    if (stream_q.size() > 3) void'(stream_q.pop_front());
    n = stream_q.size();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.t[i*3+j] = stream_q[n-3+j].v[i];
`ifdef MATRIX_EDGE_MASK_EN
    rr = (line > 2) ? 2 : line;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if ((i < 2 - rr) || (j < 2 - c)) w.t[i*3+j] = 0;
`else
    rr = line;
`endif
    exp_q.push_back(w);
  endtask

  task automatic step(input bit vs, input bit hr, input bit ck, input logic [DW-1:0] d);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int line, input int c, input logic [DW-1:0] d);
    model_push(line, c, int'(d));
    step(1'b1, 1'b1, 1'b1, d);
  endtask

  // mode 0: pixel = 16*row+col, mode 1: random. stop_line >= 0 aborts that line with a reset.
  task automatic send_frame(input int mode, input bit gaps, input int stop_line);
    logic [DW-1:0] d;
    step(1'b1, 1'b0, 1'b0, '0);
    for (int l = 0; l < H; l++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps && ($urandom_range(0, 2) == 0))
          repeat ($urandom_range(1, 3)) step(1'b1, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
        d = (mode == 0) ? DW'(16 * l + c) : DW'($urandom_range(0, 255));
        pixel(l, c, d);
        if (l == stop_line && c == 1) begin
          step(1'b1, 1'b1, 1'b0, '0);
          step(1'b1, 1'b1, 1'b0, '0);
          rst_n = 1'b0;
          model_reset();
          step(1'b0, 1'b0, 1'b0, '0);
          rst_n = 1'b1;
          step(1'b0, 1'b0, 1'b0, '0);
          step(1'b0, 1'b0, 1'b0, '0);
          return;
        end
      end
      repeat ($urandom_range(2, 4)) step(1'b1, 1'b0, 1'b0, '0);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Output monitor: sync strobes vs. inputs two cycles earlier, windows vs. the scoreboard.
  initial begin
    bit   hv1 = 0, hv2 = 0, hh1 = 0, hh2 = 0, hc1 = 0, hc2 = 0;
    bit   rst_low_prev = 0;
    int   got[9];
    win_t w;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = '{int'(matrix_p11), int'(matrix_p12), int'(matrix_p13),
              int'(matrix_p21), int'(matrix_p22), int'(matrix_p23),
              int'(matrix_p31), int'(matrix_p32), int'(matrix_p33)};
      check("vsync_dly", int'(matrix_frame_vsync), int'(hv2));
      check("href_dly", int'(matrix_frame_href), int'(hh2));
      check("clken_dly", int'(matrix_frame_clken), int'(hc2));
      if (rst_low_prev) begin
        for (int k = 0; k < 9; k++) check($sformatf("reset_tap%0d", k), got[k], 0);
      end
      if (matrix_frame_clken) begin
        if (exp_q.size() == 0) begin
          check("win_pending", exp_q.size(), 1);
        end else begin
          w = exp_q.pop_front();
          for (int k = 0; k < 9; k++)
            if (w.t[k] >= 0)
              check($sformatf("p%0d%0d", k / 3 + 1, k % 3 + 1), got[k], w.t[k]);
        end
      end
      if (!rst_n) begin
        hv2 = 0; hv1 = 0; hh2 = 0; hh1 = 0; hc2 = 0; hc1 = 0;
      end else begin
        hv2 = hv1; hv1 = per_frame_vsync;
        hh2 = hh1; hh1 = per_frame_href;
        hc2 = hc1; hc1 = per_frame_clken;
      end
      rst_low_prev = !rst_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d windows outstanding", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < W; c++) begin
      last_v[c] = -1;
      prev_v[c] = -1;
    end
    model_reset();
    rst_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);

    send_frame(0, 1'b0, -1);
    send_frame(0, 1'b1, -1);
    send_frame(1, 1'b1, -1);
    send_frame(1, 1'b1, -1);
    send_frame(0, 1'b0, 2);
    send_frame(0, 1'b1, -1);
    send_frame(1, 1'b1, -1);
    send_frame(0, 1'b0, -1);

    repeat (4) step(1'b0, 1'b0, 1'b0, '0);
    check("windows_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
